// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight destinations from execute to writeback,
// stalls decode on unready operands, and emits registered bypass selects. Option macro: WB_BYPASS_EN.
module hazard_scoreboard #(
    parameter int ADDRW      = 5,
    parameter int DEPTH      = 3,
    parameter int READY_ALU  = 1,
    parameter int READY_LOAD = 2,
    parameter int SELW       = $clog2(DEPTH + 1),
    parameter int CNTW       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [ADDRW-1:0] dec_rs1,
    input  logic [ADDRW-1:0] dec_rs2,
    input  logic             dec_uses_rs1,
    input  logic             dec_uses_rs2,
    input  logic [ADDRW-1:0] dec_rd,
    input  logic             dec_writes_rd,
    input  logic             dec_is_load,
    input  logic             flush,
    output logic             stall,
    output logic [SELW-1:0]  fwd_sel_rs1,
    output logic [SELW-1:0]  fwd_sel_rs2,
    output logic [CNTW-1:0]  stall_cycles
);

    logic             r_valid   [DEPTH];
    logic [ADDRW-1:0] r_rd      [DEPTH];
    logic             r_is_load [DEPTH];
    logic [SELW-1:0]  r_sel_rs1;
    logic [SELW-1:0]  r_sel_rs2;
    logic [CNTW-1:0]  r_cnt;

    logic [ADDRW-1:0] w_src  [2];
    logic             w_uses [2];
    logic             w_haz  [2];
    logic [SELW-1:0]  w_sel  [2];
    logic             w_stall;
    logic             w_issue;

    assign w_src[0]  = dec_rs1;
    assign w_src[1]  = dec_rs2;
    assign w_uses[0] = dec_uses_rs1;
    assign w_uses[1] = dec_uses_rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            logic            w_haz_l;
            logic [SELW-1:0] w_sel_l;

            // Scan oldest to youngest so the youngest matching producer is the last one applied.
            always_comb begin
                w_haz_l = 1'b0;
                w_sel_l = '0;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (w_uses[gi] && r_valid[k] && (r_rd[k] == w_src[gi])) begin
                        if (k == DEPTH - 1) begin
`ifdef WB_BYPASS_EN
                            w_haz_l = 1'b0;
`else
                            w_haz_l = 1'b1;
`endif
                            w_sel_l = '0;
                        end else if (k + 1 >= (r_is_load[k] ? READY_LOAD : READY_ALU)) begin
                            w_haz_l = 1'b0;
                            w_sel_l = SELW'(k + 1);
                        end else begin
                            w_haz_l = 1'b1;
                            w_sel_l = '0;
                        end
                    end
                end
            end

            assign w_haz[gi] = w_haz_l;
            assign w_sel[gi] = w_sel_l;
        end
    endgenerate

    assign w_stall = !reset && dec_valid && !flush && (w_haz[0] || w_haz[1]);
    assign w_issue = dec_valid && !w_stall && !flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_valid[k]   <= 1'b0;
                r_rd[k]      <= '0;
                r_is_load[k] <= 1'b0;
            end
            r_sel_rs1 <= '0;
            r_sel_rs2 <= '0;
            r_cnt     <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_valid[k]   <= r_valid[k-1];
                r_rd[k]      <= r_rd[k-1];
                r_is_load[k] <= r_is_load[k-1];
            end
            // x0 writers and non-writers enter execute as bubbles.
            r_valid[0]   <= w_issue && dec_writes_rd && (dec_rd != '0);
            r_rd[0]      <= dec_rd;
            r_is_load[0] <= w_issue && dec_is_load;
            r_sel_rs1    <= w_issue ? w_sel[0] : '0;
            r_sel_rs2    <= w_issue ? w_sel[1] : '0;
            if (w_stall && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stall        = w_stall;
    assign fwd_sel_rs1  = r_sel_rs1;
    assign fwd_sel_rs2  = r_sel_rs2;
    assign stall_cycles = r_cnt;

endmodule
